word_serializer: RTL
====================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter switch_bits, default 1: select width; n_cell = 2**switch_bits words per frame.
REQ-002 The block SHALL have parameter data_width, default 8: width of one word.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_valid, input, 1: upstream offers a frame.
REQ-006 The block SHALL have port load_ready, output, 1: block can accept a frame this cycle.
REQ-007 The block SHALL have port load_data, input, n_cell*data_width: frame; word i at bits [i*data_width +: data_width].
REQ-008 The block SHALL have port load_count, input, switch_bits: number of words to emit, minus one.
REQ-009 The block SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-011 The block SHALL have port out_data, output, data_width: current word = stored word[sel].
REQ-012 The block SHALL have port out_sel, output, switch_bits: index of the current word (mux select).
REQ-013 The block SHALL have port out_last, output, 1: current word is the final word of the frame.
REQ-014 The block SHALL have port flush, input, 1: synchronous abort of the current frame.

Function
REQ-015 The block SHALL implement two states: IDLE and SEND.
REQ-016 A load handshake SHALL occur when load_valid && load_ready at a rising edge: all words and load_count are captured, sel = 0, state -> SEND.
REQ-017 load_ready SHALL be 1 in IDLE, and 1 in SEND only in the cycle where out_valid && out_ready && out_last (back-to-back frames); it SHALL be 0 otherwise.
REQ-018 out_valid SHALL be 1 exactly when state is SEND; the first word SHALL appear one cycle after the load handshake.
REQ-019 out_data SHALL be a combinational selection of the stored word at index out_sel; out_sel SHALL equal sel.
REQ-020 out_last SHALL be 1 when out_valid && sel == stored load_count.
REQ-021 An output handshake (out_valid && out_ready) with out_last = 0 SHALL increment sel by 1.
REQ-022 An output handshake with out_last = 1 and no simultaneous load handshake SHALL return the block to IDLE with sel = 0.
REQ-023 An output handshake with out_last = 1 and a simultaneous load handshake SHALL capture the new frame, keep state SEND, set sel = 0, and produce no idle bubble.
REQ-024 While out_valid && !out_ready, out_data, out_sel, and out_last SHALL hold stable.
REQ-025 When load_count = n_cell-1, sel SHALL reach n_cell-1 and SHALL never wrap past it within a frame.
REQ-026 When load_count = 0, exactly one word SHALL be emitted, with out_last = 1.
REQ-027 The stored frame SHALL change only on a load handshake; load_data changes at any other time SHALL be ignored.
REQ-028 flush = 1 at a rising edge SHALL force IDLE with sel = 0, discard the remaining words, and take priority over all handshakes in that cycle; no load SHALL be accepted in that cycle.

Reset
REQ-029 While rst_n = 0, the outputs SHALL be: state IDLE, sel 0, out_valid 0, out_last 0, out_sel 0, stored words 0 (out_data 0), load_ready 1.
REQ-030 Assertion of rst_n SHALL take effect immediately, without a clock edge, including mid-frame; no load handshake SHALL be recognised while rst_n = 0.
REQ-031 After rst_n deasserts, the first rising edge SHALL be able to accept a load.

Verification (switch_bits = 2, data_width = 8)
REQ-032 Load frame {0x44,0x33,0x22,0x11}, load_count = 3, out_ready = 1 throughout -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after the load, out_last only on 0x44, then out_valid = 0.
REQ-033 Same frame with out_ready toggling 1,0,0,1,... -> each word held stable while stalled; order and out_sel sequence 0..3 are preserved.
REQ-034 Two frames, the second with load_valid held high -> the second frame's load_ready pulses in the cycle of the first frame's last handshake; no gap cycle with out_valid = 0 between frames.
REQ-035 load_count = 0, frame word0 = 0xA5 -> a single word 0xA5 with out_last = 1, then IDLE.
REQ-036 flush asserted after the 2nd word is accepted -> out_valid = 0 on the next cycle and load_ready = 1.
REQ-037 rst_n pulled low asynchronously mid-frame -> out_valid and out_data drop to 0 before the next clock edge; the next load restarts at sel = 0.

Source files
------------

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - frame-to-word serializer with back-to-back reload and flush
module word_serializer #(
  parameter int switch_bits = 1,
  parameter int data_width  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load_valid,
  output logic                                      load_ready,
  input  logic [(2**switch_bits)*data_width-1:0]    load_data,
  input  logic [switch_bits-1:0]                    load_count,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [data_width-1:0]                     out_data,
  output logic [switch_bits-1:0]                    out_sel,
  output logic                                      out_last,
  input  logic                                      flush
);

  localparam int n_cell      = 2**switch_bits;
  localparam int frame_width = n_cell*data_width;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [switch_bits-1:0]   sel_q, sel_d;
  logic [switch_bits-1:0]   count_q, count_d;
  logic [frame_width-1:0]   frame_q, frame_d;

  logic load_hs;
  logic out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      count_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      frame_q <= frame_d;
    end
  end

  // flush wins over both handshakes; a load only lands when the current frame is done
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    count_d = count_q;
    frame_d = frame_q;
    load_hs = load_valid && load_ready && !flush;
    out_hs  = out_valid && out_ready;
    if (flush) begin
      state_d = IDLE;
      sel_d   = '0;
    end else if (load_hs) begin
      state_d = SEND;
      sel_d   = '0;
      count_d = load_count;
      frame_d = load_data;
    end else if (out_hs) begin
      if (out_last) begin
        state_d = IDLE;
        sel_d   = '0;
      end else begin
        sel_d = sel_q + switch_bits'(1);
      end
    end
  end

  always_comb begin
    out_valid  = (state_q == SEND);
    out_sel    = sel_q;
    out_last   = out_valid && (sel_q == count_q);
    out_data   = frame_q[sel_q*data_width +: data_width];
    load_ready = (state_q == IDLE) || (out_valid && out_ready && out_last);
  end

endmodule
